axil_reg_arbiter: RTL and testbench
===================================

AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of register 0 of the downstream AXI4-Lite slave.
REQ-002 Parameter NUM_REGS, default 4, number of 32-bit registers behind the slave.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETN  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  2  per-requester command valid (bit i = requester i).
REQ-006 req_ready  out  2  per-requester command accepted, one-cycle pulse.
REQ-007 req_write  in  2  per-requester 1 = write, 0 = read.
REQ-008 req_addr  in  64  requester i address at bits [32i+31:32i].
REQ-009 req_wdata  in  64  requester i write data at bits [32i+31:32i].
REQ-010 rsp_valid  out  2  per-requester completion pulse; no back-pressure.
REQ-011 rsp_data  out  32  read data (0 for writes), qualified by rsp_valid.
REQ-012 rsp_resp  out  2  AXI response code, qualified by rsp_valid.
REQ-013 M_AXI_AWADDR/AWVALID out 32/1, M_AXI_AWREADY in 1: write address channel.
REQ-014 M_AXI_WDATA/WVALID out 32/1, M_AXI_WREADY in 1: write data channel.
REQ-015 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write response channel.
REQ-016 M_AXI_ARADDR/ARVALID out 32/1, M_AXI_ARREADY in 1: read address channel.
REQ-017 M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read data channel.
REQ-018 M_AXI_AWPROT, M_AXI_ARPROT out 3 tied 3'b000; M_AXI_WSTRB out 4 tied 4'hF.

Function
REQ-019 FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP; exactly one AXI transaction outstanding.
REQ-020 IDLE: grant among asserted req_valid by 2-way round-robin; both valid -> requester not granted last; lone requester always wins.
REQ-021 Grant cycle: req_ready[g]=1, capture write/addr/wdata/g; next state WR_ADDR_DATA or RD_ADDR.
REQ-022 Requesters hold req_valid and payload stable until req_ready; requests are never dropped or reordered per requester.
REQ-023 WR_ADDR_DATA: AWVALID and WVALID rise together, each drops independently on its own handshake; go WR_RESP once both have completed (same-cycle completion allowed).
REQ-024 WR_RESP: BREADY=1; on BVALID capture BRESP, rsp_data=0, go RESP.
REQ-025 RD_ADDR: ARVALID=1 until ARREADY; RD_DATA: RREADY=1, on RVALID capture RDATA/RRESP, go RESP.
REQ-026 RESP: rsp_valid[g]=1 for exactly one cycle with captured data/resp; return IDLE; arbitration resumes the following cycle.
REQ-027 Latency with zero-wait slave: grant at cycle T -> rsp_valid at T+3; throughput one transaction per 4 cycles.
REQ-028 AWADDR/ARADDR = captured address with bits [1:0] forced to 0.
REQ-029 Slave SLVERR/DECERR passed through unmodified in rsp_resp.

Reset
REQ-030 ARESETN low at a rising edge: state IDLE, all VALID/READY outputs and rsp_valid/req_ready 0, rsp_data/rsp_resp 0, round-robin favours requester 0.
REQ-031 Reset mid-transaction abandons it; no rsp_valid is issued for it.

Configuration
REQ-032 Macro AXIL_ARB_ADDR_CHECK_EN defined: address outside [BASE_ADDR, BASE_ADDR+4*NUM_REGS) or with bits [1:0] nonzero skips the AXI bus, goes IDLE->RESP directly, returns rsp_resp=2'b10, rsp_data=0, rsp_valid at T+1.
REQ-033 Macro undefined: every address is forwarded per REQ-028; no local errors are generated.

Structure
REQ-034 Package axil_arb_pkg holds the state enum, RESP_OKAY=2'b00 / RESP_SLVERR=2'b10 constants and the default WSTRB/PROT values.
REQ-035 Sub-module axil_rr_arbiter (2-way round-robin grant with last-grant register) is instantiated once.

Verification
REQ-036 Requester 0 writes 0x0101FFFF to 0x0 and reads it back -> one AW/W/B then one AR/R on the bus; rsp_data=0x0101FFFF, rsp_resp=0, rsp_valid at T+3.
REQ-037 Both requesters valid every cycle, writing 0xabcd0001 to 0x4 and 0xdead0011 to 0x8 -> grants alternate 0,1,0,1 and no request is lost.
REQ-038 Slave delays AWREADY 3 cycles and WREADY 0 cycles, data 0xbeef0011 to 0xC -> WVALID drops after 1 cycle, AWVALID is held 4 cycles, single response.
REQ-039 Slave returns RRESP=2'b10 on a read of 0x8 -> rsp_resp=2'b10 to the granted requester.
REQ-040 With AXIL_ARB_ADDR_CHECK_EN, read of 0x10 -> no ARVALID, rsp_resp=2'b10 at T+1; ARESETN low during RD_DATA -> all outputs 0 next cycle, no rsp_valid.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite register arbiter.
// Optional feature macro used by the top: AXIL_ARB_ADDR_CHECK_EN.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [3:0] WSTRB_ALL    = 4'hF;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Registers are word-wide, so the byte offset never reaches the bus.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/axil_reg_arbiter_if.sv
// AXI4-Lite master-side bus bundle (all five channels).
interface axil_reg_arbiter_if;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_rr_arbiter.sv
// Two-way round-robin grant with a last-grant register.
module axil_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    logic last;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        gnt_idx = (req == 2'b11) ? ~last : req[1];
        gnt     = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
    end

    // Reset to "1 served last" so requester 0 is favoured first.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (take && (req != 2'b00))
            last <= gnt_idx;
    end
endmodule

// File: rtl/axil_reg_arbiter.sv
// Two-requester arbiter in front of a single AXI4-Lite register slave.
// One AXI transaction is outstanding at a time.
// Macro AXIL_ARB_ADDR_CHECK_EN: reject out-of-window or unaligned addresses
// locally with SLVERR instead of forwarding them.
module axil_reg_arbiter
    import axil_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_resp,
    axil_reg_arbiter_if.master m_axi
);
`ifdef AXIL_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    arb_state_t  state, state_n;
    logic [1:0]  gnt;
    logic        gnt_idx, take, addr_bad;
    logic [31:0] sel_addr, sel_wdata, cap_addr, cap_wdata;
    logic        sel_write, cap_g, aw_done, w_done;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [32:0] addr_ext, lim_lo, lim_hi;

    // Never grant while reset is asserted: the FSM would not advance and the
    // requester would see a phantom acceptance.
    assign take = (state == IDLE) && ARESETN && (req_valid != 2'b00);

    axil_rr_arbiter u_rr (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .req     (req_valid),
        .take    (take),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_addr  = gnt_idx ? req_addr[63:32]  : req_addr[31:0];
    assign sel_wdata = gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
    assign sel_write = req_write[gnt_idx];

    assign addr_ext = {1'b0, sel_addr};
    assign lim_lo   = {1'b0, BASE_ADDR};
    assign lim_hi   = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);
    assign addr_bad = ADDR_CHECK && ((sel_addr[1:0] != 2'b00) ||
                                     (addr_ext < lim_lo) || (addr_ext >= lim_hi));

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_n;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_n   = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    req_ready = gnt;
                    if (addr_bad)       state_n = RESP;
                    else if (sel_write) state_n = WR_ADDR_DATA;
                    else                state_n = RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                aw_valid = !aw_done;
                w_valid  = !w_done;
                if ((aw_done || m_axi.AWREADY) && (w_done || m_axi.WREADY))
                    state_n = WR_RESP;
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (m_axi.BVALID) state_n = RESP;
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (m_axi.ARREADY) state_n = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (m_axi.RVALID) state_n = RESP;
            end
            RESP: begin
                rsp_valid = cap_g ? 2'b10 : 2'b01;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Command capture, per-channel write progress and response capture.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_g     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= '0;
        end else begin
            if (take) begin
                cap_addr  <= sel_addr;
                cap_wdata <= sel_wdata;
                cap_g     <= gnt_idx;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                if (addr_bad) begin
                    rsp_data <= '0;
                    rsp_resp <= RESP_SLVERR;
                end
            end
            if (aw_valid && m_axi.AWREADY) aw_done <= 1'b1;
            if (w_valid && m_axi.WREADY)   w_done  <= 1'b1;
            if (b_ready && m_axi.BVALID) begin
                rsp_data <= '0;
                rsp_resp <= m_axi.BRESP;
            end
            if (r_ready && m_axi.RVALID) begin
                rsp_data <= m_axi.RDATA;
                rsp_resp <= m_axi.RRESP;
            end
        end
    end

    assign m_axi.AWADDR  = word_align(cap_addr);
    assign m_axi.AWPROT  = PROT_DEFAULT;
    assign m_axi.AWVALID = aw_valid;
    assign m_axi.WDATA   = cap_wdata;
    assign m_axi.WSTRB   = WSTRB_ALL;
    assign m_axi.WVALID  = w_valid;
    assign m_axi.BREADY  = b_ready;
    assign m_axi.ARADDR  = word_align(cap_addr);
    assign m_axi.ARPROT  = PROT_DEFAULT;
    assign m_axi.ARVALID = ar_valid;
    assign m_axi.RREADY  = r_ready;
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Scoreboard bench for axil_reg_arbiter: a randomized AXI4-Lite slave, a
// register-file reference model, and a negedge monitor that checks grants,
// bus beats and responses. Expectations follow AXIL_ARB_ADDR_CHECK_EN.
module tb_axil_reg_arbiter;
    import axil_arb_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NREG = 4;
`ifdef AXIL_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } cmd_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        v0, v1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_resp;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    assign req_valid = {v1, v0};
    assign req_write = {w1, w0};
    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    axil_reg_arbiter_if bus ();

    axil_reg_arbiter #(.BASE_ADDR(BASE), .NUM_REGS(NREG)) dut (
        .ACLK(clk), .ARESETN(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .m_axi(bus)
    );

    // ---------------- slave BFM ----------------
    bit          fixed, inject;
    int          f_aw, f_w, f_b, f_ar, f_r;
    int          d_aw, d_w, d_b, d_ar, d_r;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_got, w_got, r_pend;
    logic [31:0] aw_a, w_d, ar_a, smem [NREG];
    logic        s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    function automatic bit in_rng(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < {1'b0, BASE} + 33'(4 * NREG));
    endfunction

    assign bus.AWREADY = bus.AWVALID && (aw_wait >= (fixed ? f_aw : d_aw));
    assign bus.WREADY  = bus.WVALID  && (w_wait  >= (fixed ? f_w  : d_w));
    assign bus.ARREADY = bus.ARVALID && (ar_wait >= (fixed ? f_ar : d_ar));
    assign bus.BVALID  = s_bvalid;
    assign bus.BRESP   = s_bresp;
    assign bus.RVALID  = s_rvalid;
    assign bus.RDATA   = s_rdata;
    assign bus.RRESP   = s_rresp;

    always @(posedge clk) begin : slave
        bit hs_aw, hs_w, hs_ar, have_aw, have_w, pend;
        logic [31:0] a, d, ra;
        if (!rstn) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            d_aw <= 0; d_w <= 0; d_b <= 0; d_ar <= 0; d_r <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00;
            s_rdata <= '0; aw_a <= '0; w_d <= '0; ar_a <= '0;
            for (int i = 0; i < NREG; i++) smem[i] <= '0;
        end else begin
            hs_aw = bus.AWVALID && bus.AWREADY;
            hs_w  = bus.WVALID && bus.WREADY;
            hs_ar = bus.ARVALID && bus.ARREADY;
            if (hs_aw) begin aw_a <= bus.AWADDR; aw_wait <= 0; d_aw <= $urandom_range(3); end
            else if (bus.AWVALID) aw_wait <= aw_wait + 1;
            if (hs_w) begin w_d <= bus.WDATA; w_wait <= 0; d_w <= $urandom_range(3); end
            else if (bus.WVALID) w_wait <= w_wait + 1;
            if (hs_ar) begin ar_a <= bus.ARADDR; ar_wait <= 0; d_ar <= $urandom_range(3); end
            else if (bus.ARVALID) ar_wait <= ar_wait + 1;

            have_aw = aw_got || hs_aw;
            have_w  = w_got || hs_w;
            a  = hs_aw ? bus.AWADDR : aw_a;
            d  = hs_w ? bus.WDATA : w_d;
            aw_got <= have_aw;
            w_got  <= have_w;
            if (s_bvalid && bus.BREADY) s_bvalid <= 1'b0;
            if (have_aw && have_w && !s_bvalid) begin
                if (b_wait >= (fixed ? f_b : d_b)) begin
                    s_bvalid <= 1'b1; b_wait <= 0; d_b <= $urandom_range(3);
                    aw_got <= 1'b0; w_got <= 1'b0;
                    if (in_rng(a)) begin smem[(a - BASE) >> 2] <= d; s_bresp <= 2'b00; end
                    else s_bresp <= 2'b11;
                end else b_wait <= b_wait + 1;
            end

            pend = r_pend || hs_ar;
            ra   = hs_ar ? bus.ARADDR : ar_a;
            r_pend <= pend;
            if (s_rvalid && bus.RREADY) s_rvalid <= 1'b0;
            if (pend && !s_rvalid) begin
                if (r_wait >= (fixed ? f_r : d_r)) begin
                    s_rvalid <= 1'b1; r_pend <= 1'b0; r_wait <= 0; d_r <= $urandom_range(3);
                    if (!in_rng(ra)) begin s_rdata <= '0; s_rresp <= 2'b11; end
                    else begin
                        s_rdata <= smem[(ra - BASE) >> 2];
                        s_rresp <= (inject && ((ra - BASE) >> 2) == 2) ? 2'b10 : 2'b00;
                    end
                end else r_wait <= r_wait + 1;
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    int          vec = 0, miss = 0, cyc = 0, grant_cyc = 0, cur_lat = 3;
    int          exp_bus = 0, bus_seen = 0, aw_hi = 0, w_hi = 0;
    bit          last_g = 1'b1, cur_wr, cur_loc;
    logic [31:0] cur_addr, cur_data, mmem [NREG];
    exp_t        eq0[$], eq1[$];
    cmd_t        sq0[$], sq1[$];
    bit          lat_chk, chk_zero, chk_end, chk_hi, clr_cnt, tmo;
    int          exp_aw_hi, exp_w_hi;

    always @(negedge clk) begin : mon
        bit g, eg, inr, rr;
        int idx;
        exp_t e;
        cyc++;
        if (clr_cnt) begin aw_hi = 0; w_hi = 0; end
        if (!rstn) begin
            last_g = 1'b1;
            eq0.delete(); eq1.delete();
            exp_bus = bus_seen;
            for (int i = 0; i < NREG; i++) mmem[i] = '0;
        end else begin
            if (req_ready != 2'b00) begin
                g  = req_ready[1];
                eg = (req_valid == 2'b11) ? ~last_g : req_valid[1];
                vec++;
                if (!((req_ready == 2'b01) || (req_ready == 2'b10)) || ((req_ready & ~req_valid) != 2'b00) || g != eg) begin
                    miss++;
                    $display("FAIL grant: req_valid=%b req_ready=%b, required grant to requester %0d", req_valid, req_ready, eg);
                end
                last_g   = g;
                cur_addr = g ? a1 : a0;
                cur_data = g ? d1 : d0;
                cur_wr   = g ? w1 : w0;
                inr      = in_rng(cur_addr);
                idx      = int'((cur_addr - BASE) >> 2);
                cur_loc  = ADDR_CHK && (!inr || cur_addr[1:0] != 2'b00);
                grant_cyc = cyc;
                cur_lat   = cur_loc ? 1 : 3;
                if (cur_loc) e = '{32'h0, RESP_SLVERR};
                else begin
                    exp_bus++;
                    if (!inr) e = '{32'h0, 2'b11};
                    else if (cur_wr) begin mmem[idx] = cur_data; e = '{32'h0, RESP_OKAY}; end
                    else e = '{mmem[idx], (inject && idx == 2) ? RESP_SLVERR : RESP_OKAY};
                end
                if (g) eq1.push_back(e); else eq0.push_back(e);
            end
            if (bus.AWVALID && bus.AWREADY) begin
                vec++;
                if (cur_loc || !cur_wr || bus.AWADDR !== {cur_addr[31:2], 2'b00}) begin
                    miss++; $display("FAIL awaddr: got %h, required %h", bus.AWADDR, {cur_addr[31:2], 2'b00});
                end
            end
            if (bus.WVALID && bus.WREADY) begin
                vec++;
                if (cur_loc || !cur_wr || bus.WDATA !== cur_data) begin
                    miss++; $display("FAIL wdata: got %h, required %h", bus.WDATA, cur_data);
                end
            end
            if (bus.ARVALID && bus.ARREADY) begin
                vec++;
                if (cur_loc || cur_wr || bus.ARADDR !== {cur_addr[31:2], 2'b00}) begin
                    miss++; $display("FAIL araddr: got %h, required %h", bus.ARADDR, {cur_addr[31:2], 2'b00});
                end
            end
            if (bus.AWVALID) aw_hi++;
            if (bus.WVALID)  w_hi++;
            if ((bus.BVALID && bus.BREADY) || (bus.RVALID && bus.RREADY)) bus_seen++;
            if (rsp_valid != 2'b00) begin
                vec++;
                rr = rsp_valid[1];
                if (rsp_valid == 2'b11) begin
                    miss++; $display("FAIL rsp_onehot: rsp_valid=%b, required a single bit", rsp_valid);
                end else if ((rr ? eq1.size() : eq0.size()) == 0) begin
                    miss++; $display("FAIL rsp_unexpected: requester %0d data=%h resp=%b, required no response", rr, rsp_data, rsp_resp);
                end else begin
                    if (rr) e = eq1.pop_front(); else e = eq0.pop_front();
                    if (rsp_data !== e.data || rsp_resp !== e.resp) begin
                        miss++; $display("FAIL rsp_payload: req %0d data=%h resp=%b, required data=%h resp=%b", rr, rsp_data, rsp_resp, e.data, e.resp);
                    end
                end
                if (lat_chk) begin
                    vec++;
                    if (cyc - grant_cyc != cur_lat) begin
                        miss++; $display("FAIL latency: got %0d cycles, required %0d", cyc - grant_cyc, cur_lat);
                    end
                end
            end
        end
        if (chk_zero) begin
            vec++;
            if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, req_ready, rsp_valid, rsp_data, rsp_resp} != '0) begin
                miss++; $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b rsp_data=%h rsp_resp=%b aw=%b w=%b b=%b ar=%b r=%b, required all 0",
                                 req_ready, rsp_valid, rsp_data, rsp_resp, bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY);
            end
        end
        if (chk_end) begin
            vec++;
            if (bus_seen != exp_bus) begin
                miss++; $display("FAIL bus_count: got %0d transactions, required %0d", bus_seen, exp_bus);
            end
        end
        if (chk_hi) begin
            vec++;
            if (aw_hi != exp_aw_hi || w_hi != exp_w_hi) begin
                miss++; $display("FAIL valid_cycles: AWVALID %0d WVALID %0d, required %0d %0d", aw_hi, w_hi, exp_aw_hi, exp_w_hi);
            end
        end
        if (tmo) begin
            vec++; miss++;
            $display("FAIL timeout: phase did not complete within its cycle budget");
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_flag(input int which);
        @(posedge clk); #1;
        case (which)
            0: chk_zero = 1'b1;
            1: chk_end  = 1'b1;
            2: chk_hi   = 1'b1;
            3: clr_cnt  = 1'b1;
            default: tmo = 1'b1;
        endcase
        @(negedge clk); #1;
        chk_zero = 1'b0; chk_end = 1'b0; chk_hi = 1'b0; clr_cnt = 1'b0; tmo = 1'b0;
    endtask

    task automatic set_zero_wait();
        fixed = 1'b1; f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
    endtask

    task automatic recover();
        pulse_flag(4);
        sq0.delete(); sq1.delete();
        @(posedge clk); #1; rstn = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1;
    endtask

    task automatic run_phase(input int idle_pct, input int budget);
        int  n = 0;
        bit  acc0, acc1;
        cmd_t c;
        forever begin
            if (!v0 && !v1 && sq0.size() == 0 && sq1.size() == 0 && eq0.size() == 0 && eq1.size() == 0) break;
            if (n >= budget) begin recover(); break; end
            @(negedge clk);
            acc0 = v0 && req_ready[0];
            acc1 = v1 && req_ready[1];
            @(posedge clk); #1; n++;
            if (!v0 || acc0) begin
                if (sq0.size() != 0 && $urandom_range(99) >= idle_pct) begin
                    c = sq0.pop_front(); v0 = 1'b1; w0 = c.wr; a0 = c.addr; d0 = c.data;
                end else v0 = 1'b0;
            end
            if (!v1 || acc1) begin
                if (sq1.size() != 0 && $urandom_range(99) >= idle_pct) begin
                    c = sq1.pop_front(); v1 = 1'b1; w1 = c.wr; a1 = c.addr; d1 = c.data;
                end else v1 = 1'b0;
            end
        end
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        int   k = $urandom_range(9);
        c.wr   = 1'($urandom_range(1));
        c.data = $urandom;
        if (k <= 6)      c.addr = BASE + 32'(4 * $urandom_range(NREG - 1));
        else if (k == 7) c.addr = BASE + 32'(4 * $urandom_range(NREG - 1)) + 32'($urandom_range(3, 1));
        else             c.addr = BASE + 32'(4 * NREG) + 32'($urandom_range(15));
        return c;
    endfunction

    initial begin
        int n;
        rstn = 1'b0; v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        lat_chk = 1'b0; chk_zero = 1'b0; chk_end = 1'b0; chk_hi = 1'b0; clr_cnt = 1'b0; tmo = 1'b0;
        inject = 1'b0; exp_aw_hi = 0; exp_w_hi = 0;
        set_zero_wait();
        repeat (2) @(posedge clk);
        pulse_flag(0);
        @(posedge clk); #1; rstn = 1'b1;

        // write then read back, zero-wait slave, latency 3
        lat_chk = 1'b1;
        sq0.push_back('{1'b1, 32'h0, 32'h0101FFFF});
        sq0.push_back('{1'b0, 32'h0, 32'h0});
        run_phase(0, 100);

        // both requesters hammering: grants must alternate
        for (int i = 0; i < 4; i++) begin
            sq0.push_back('{1'b1, 32'h4, 32'habcd0001});
            sq1.push_back('{1'b1, 32'h8, 32'hdead0011});
        end
        sq0.push_back('{1'b0, 32'h8, 32'h0});
        sq1.push_back('{1'b0, 32'h4, 32'h0});
        run_phase(0, 200);

        // slow AWREADY, immediate WREADY
        lat_chk = 1'b0;
        f_aw = 3;
        pulse_flag(3);
        sq0.push_back('{1'b1, 32'hC, 32'hbeef0011});
        run_phase(0, 100);
        exp_aw_hi = 4; exp_w_hi = 1;
        pulse_flag(2);
        set_zero_wait();
        sq1.push_back('{1'b0, 32'hC, 32'h0});
        run_phase(0, 100);

        // slave error passthrough on a read of register 2
        inject = 1'b1;
        sq1.push_back('{1'b0, 32'h8, 32'h0});
        run_phase(0, 100);
        inject = 1'b0;

        // out-of-window and unaligned addresses
        lat_chk = 1'b1;
        sq0.push_back('{1'b0, 32'h10, 32'h0});
        sq0.push_back('{1'b1, 32'h5, 32'h12345678});
        sq1.push_back('{1'b0, 32'h4, 32'h0});
        sq1.push_back('{1'b1, 32'h14, 32'h55AA55AA});
        run_phase(0, 200);

        // randomized traffic with random slave stalls
        lat_chk = 1'b0; fixed = 1'b0; inject = 1'b1;
        for (int i = 0; i < 30; i++) begin
            sq0.push_back(rnd_cmd());
            sq1.push_back(rnd_cmd());
        end
        run_phase(30, 3000);
        inject = 1'b0;
        pulse_flag(1);

        // reset while a read sits in the data phase
        set_zero_wait(); f_r = 20;
        @(posedge clk); #1; v0 = 1'b1; w0 = 1'b0; a0 = 32'h4;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 10);
        @(posedge clk); #1; v0 = 1'b0;
        n = 0;
        while (!bus.RREADY && n < 10) begin @(negedge clk); n++; end
        if (!bus.RREADY) recover();
        else begin
            @(posedge clk); #1; rstn = 1'b0;
            pulse_flag(0);
            @(posedge clk); #1; rstn = 1'b1;
        end
        set_zero_wait();
        repeat (25) @(posedge clk);
        sq0.push_back('{1'b1, 32'h0, 32'h11112222});
        sq1.push_back('{1'b1, 32'h4, 32'h33334444});
        sq0.push_back('{1'b0, 32'h4, 32'h0});
        sq1.push_back('{1'b0, 32'h0, 32'h0});
        run_phase(0, 200);
        pulse_flag(1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
